// File: rtl/key_event_if.sv
// Key event bundle between a per-key debouncer/driver (master) and the gesture decoder (slave).
interface key_event_if;
    logic key_state;
    logic evt_single;
    logic evt_double;
    logic evt_long;
    logic evt_repeat;
    logic key_busy;

    modport master (
        output key_state,
        input  evt_single,
        input  evt_double,
        input  evt_long,
        input  evt_repeat,
        input  key_busy
    );

    modport slave (
        input  key_state,
        output evt_single,
        output evt_double,
        output evt_long,
        output evt_repeat,
        output key_busy
    );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into single/double/long press pulses.
// Optional macro KEY_REPEAT_EN adds auto-repeat pulses while a long press is held.
//
// state     | meaning
// IDLE      | key released, waiting for a new press
// PRESS1    | first press held, timing toward a long press
// WAIT_GAP  | first press released, waiting for a second press
// WAIT_REL  | double press reported, waiting for release
// LONG_HOLD | long press reported, waiting for release (repeats if enabled)
module key_event_decoder #(
    parameter logic [24:0] LONG_CNT   = 25'd27_000_000,
    parameter logic [24:0] GAP_CNT    = 25'd8_100_000,
    parameter logic [24:0] REPEAT_CNT = 25'd5_400_000
) (
    input logic        sys_clk,
    input logic        rst_in,
    key_event_if.slave kev
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        WAIT_REL,
        LONG_HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [24:0] cnt;
    logic [24:0] cnt_nx;
    logic [24:0] cnt_tc;
    logic        cnt_done;
    logic        key_prev;
    logic        key_rise;

    logic        single_q, double_q, long_q, busy_q;
    logic        single_nx, double_nx, long_nx;

    assign key_rise = kev.key_state & ~key_prev;

    // One shared counter; its terminal value depends on which interval is being timed.
    always_comb begin
        cnt_tc = '0;
        case (state)
            PRESS1:    cnt_tc = LONG_CNT - 25'd1;
            WAIT_GAP:  cnt_tc = GAP_CNT - 25'd1;
            LONG_HOLD: cnt_tc = REPEAT_CNT - 25'd1;
            default:   cnt_tc = '0;
        endcase
    end

    assign cnt_done = (cnt == cnt_tc);

`ifdef KEY_REPEAT_EN
    logic repeat_q;
    logic repeat_nx;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        single_nx = 1'b0;
        double_nx = 1'b0;
        long_nx   = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (key_rise) state_nx = PRESS1;
            end
            PRESS1: begin
                if (!kev.key_state) begin
                    state_nx = WAIT_GAP;
                end else if (cnt_done) begin
                    long_nx  = 1'b1;
                    state_nx = LONG_HOLD;
                end else begin
                    cnt_nx = cnt + 25'd1;
                end
            end
            WAIT_GAP: begin
                if (kev.key_state) begin
                    double_nx = 1'b1;
                    state_nx  = WAIT_REL;
                end else if (cnt_done) begin
                    single_nx = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt + 25'd1;
                end
            end
            WAIT_REL: begin
                if (!kev.key_state) state_nx = IDLE;
            end
            LONG_HOLD: begin
                if (!kev.key_state) begin
                    state_nx = IDLE;
`ifdef KEY_REPEAT_EN
                end else if (cnt_done) begin
                    repeat_nx = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx = cnt + 25'd1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx != state) cnt_nx = '0;
    end

    always_ff @(posedge sys_clk or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            key_prev <= 1'b1;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            key_prev <= kev.key_state;
            single_q <= single_nx;
            double_q <= double_nx;
            long_q   <= long_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge sys_clk or posedge rst_in) begin
        if (rst_in) repeat_q <= 1'b0;
        else        repeat_q <= repeat_nx;
    end
    assign kev.evt_repeat = repeat_q;
`else
    assign kev.evt_repeat = 1'b0;
`endif

    assign kev.evt_single = single_q;
    assign kev.evt_double = double_q;
    assign kev.evt_long   = long_q;
    assign kev.key_busy   = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed scoreboard bench for key_event_decoder (LONG=20, GAP=8, REPEAT=5).
module tb_key_event_decoder;

    localparam logic [24:0] LONG_P = 25'd20;
    localparam logic [24:0] GAP_P  = 25'd8;
    localparam logic [24:0] REP_P  = 25'd5;

    localparam logic [3:0] EV_SINGLE = 4'b1000;
    localparam logic [3:0] EV_DOUBLE = 4'b0100;
    localparam logic [3:0] EV_LONG   = 4'b0010;
    localparam logic [3:0] EV_REPEAT = 4'b0001;

    typedef struct {
        logic [3:0] ev;
        int         cyc;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_in  = 1'b1;

    key_event_if kev ();

    key_event_decoder #(
        .LONG_CNT  (LONG_P),
        .GAP_CNT   (GAP_P),
        .REPEAT_CNT(REP_P)
    ) dut (
        .sys_clk(sys_clk),
        .rst_in (rst_in),
        .kev    (kev)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   e0;
    int   g0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] ev, input int at);
        exp_t e;
        e.ev  = ev;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Events observed after each edge are matched against the scoreboard head.
    task automatic monitor();
        logic [3:0] obs;
        exp_t       e;
        obs = {kev.evt_single, kev.evt_double, kev.evt_long, kev.evt_repeat};
        if (obs != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {28'd0, obs}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {28'd0, obs}, {28'd0, e.ev});
                check("event_edge", cyc, e.cyc);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            cyc++;
            #1;
            monitor();
        end
    endtask

    task automatic drained(input string tag);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        kev.key_state = 1'b0;

        // Reset state
        tick(2);
        check("reset_outputs", {27'd0, kev.evt_single, kev.evt_double, kev.evt_long,
                                kev.evt_repeat, kev.key_busy}, 32'd0);
        rst_in = 1'b0;
        tick(2);
        check("idle_busy", {31'd0, kev.key_busy}, 32'd0);

        // Single press: 5 high edges, then release
        kev.key_state = 1'b1;
        tick(1);
        e0 = cyc;
        check("press_busy", {31'd0, kev.key_busy}, 32'd1);
        tick(4);
        kev.key_state = 1'b0;
        push(EV_SINGLE, cyc + 1 + 8);
        tick(1);
        g0 = cyc;
        tick(8);
        check("single_edge_pos", cyc, g0 + 8);
        check("single_busy_drop", {31'd0, kev.key_busy}, 32'd0);
        tick(3);
        drained("single_drained");

        // Double press: press 5, release 4, press 5, release
        kev.key_state = 1'b1;
        tick(5);
        kev.key_state = 1'b0;
        tick(4);
        kev.key_state = 1'b1;
        push(EV_DOUBLE, cyc + 1);
        tick(5);
        kev.key_state = 1'b0;
        tick(1);
        check("double_busy_drop", {31'd0, kev.key_busy}, 32'd0);
        tick(12);
        drained("double_drained");

        // Long press held through edge e0+40
        kev.key_state = 1'b1;
        tick(1);
        e0 = cyc;
        push(EV_LONG, e0 + 20);
`ifdef KEY_REPEAT_EN
        push(EV_REPEAT, e0 + 25);
        push(EV_REPEAT, e0 + 30);
        push(EV_REPEAT, e0 + 35);
        push(EV_REPEAT, e0 + 40);
`endif
        tick(40);
        check("long_busy", {31'd0, kev.key_busy}, 32'd1);
        kev.key_state = 1'b0;
        tick(1);
        check("long_busy_drop", {31'd0, kev.key_busy}, 32'd0);
        tick(12);
        drained("long_drained");

        // Release on the same edge the long threshold would hit
        kev.key_state = 1'b1;
        tick(1);
        e0 = cyc;
        tick(19);
        kev.key_state = 1'b0;
        push(EV_SINGLE, cyc + 1 + 8);
        tick(1);
        tick(8);
        tick(3);
        drained("long_race_drained");

        // Second press on the same edge the gap would expire
        kev.key_state = 1'b1;
        tick(5);
        kev.key_state = 1'b0;
        tick(1);
        g0 = cyc;
        tick(7);
        kev.key_state = 1'b1;
        push(EV_DOUBLE, g0 + 8);
        tick(1);
        tick(3);
        kev.key_state = 1'b0;
        tick(12);
        drained("gap_race_drained");

        // Key held through reset deassertion is ignored until released
        kev.key_state = 1'b1;
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
        tick(6);
        check("held_reset_busy", {31'd0, kev.key_busy}, 32'd0);
        kev.key_state = 1'b0;
        tick(2);
        kev.key_state = 1'b1;
        tick(1);
        check("held_reset_new_press", {31'd0, kev.key_busy}, 32'd1);
        tick(4);
        kev.key_state = 1'b0;
        push(EV_SINGLE, cyc + 1 + 8);
        tick(9);
        tick(3);
        drained("held_reset_drained");

        // Reset one edge before a pending single would fire
        kev.key_state = 1'b1;
        tick(5);
        kev.key_state = 1'b0;
        tick(1);
        tick(6);
        check("gap_busy_before_rst", {31'd0, kev.key_busy}, 32'd1);
        rst_in = 1'b1;
        #1;
        check("rst_mid_gap_outputs", {27'd0, kev.evt_single, kev.evt_double, kev.evt_long,
                                      kev.evt_repeat, kev.key_busy}, 32'd0);
        tick(2);
        rst_in = 1'b0;
        tick(15);
        check("rst_mid_gap_busy", {31'd0, kev.key_busy}, 32'd0);
        drained("rst_mid_gap_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
